thee_lpf_channel_sequencer: RTL and testbench
=============================================

// Module: thee_lpf_channel_sequencer
// PURPOSE
//  Time-multiplexes one moving-average low-pass filter datapath across NCH sampled channels.
//  Round-robin arbitrates requesters and keeps a per-channel TAPS-deep history and running sum.
//  Sequences each accepted sample through accept/update/output phases.
//  Sits between the per-channel sample sources and the downstream filtered-sample consumer.
// PARAMETERS
//  NCH   4   number of requesting channels (>=2)
//  DW    12  signed sample width, in and out
//  TAPS  4   moving-average depth; power of 2, >=2; TL=$clog2(TAPS), SW=DW+TL (sum width)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst_n      in   1       asynchronous active-low reset
//  req_valid  in   NCH     per-channel sample valid
//  req_data   in   NCH*DW  per-channel signed sample; channel i at [i*DW +: DW]
//  req_ready  out  NCH     one-hot grant; sample i transfers when valid[i]&ready[i]
//  out_valid  out  1       filtered result valid
//  out_ready  in   1       consumer ready
//  out_data   out  DW      signed filtered result
//  out_ch     out  $clog2(NCH)  channel index of out_data
//  flush      in   1       synchronous clear of all channel histories
//  busy       out  1       FSM not in IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): FSM=IDLE; all outputs 0; histories, sums, write pointers and warm-up counts 0;
//   round-robin pointer set so channel 0 has top priority.
//  FSM IDLE->CALC->OUT->IDLE:
//   IDLE: if any req_valid and !flush, grant g = first valid channel at or after rr_ptr (wrapping);
//    req_ready[g]=1 combinationally this cycle only; capture sample and g; rr_ptr<=g+1 mod NCH; go CALC.
//    No valid: stay IDLE, req_ready=0.
//   CALC: oldest=hist[g][wp[g]]; sum[g]<=sum[g]+sext(sample)-oldest; hist[g][wp[g]]<=sample;
//    wp[g]<=wp[g]+1 mod TAPS; go OUT.
//   OUT: out_valid=1, out_data=new sum>>>TL (arithmetic shift, floor toward -inf; always fits DW),
//    out_ch=g; held stable until out_ready=1, then IDLE next cycle.
//  req_ready is 0 in CALC and OUT; at most one bit set at any time.
//  Latency: accept in cycle t -> out_valid from t+2; max throughput 1 sample / 3 cycles with out_ready=1.
//  Sum arithmetic in SW bits, never overflows; history zero-filled, so first outputs ramp up.
//  Unselected channels' state is never modified.
//  flush=1 (any state): next cycle FSM=IDLE, out_valid=0, all histories/sums/pointers/warm-up counts 0;
//   in-flight sample discarded, no output; rr_ptr retained; no grant while flush=1.
//  out_valid & out_ready & flush in same cycle: transfer counts as taken, then flush applies.
// CONFIGURATION
//  THEE_LPF_WARMUP_EN defined: per-channel counter saturating at TAPS; CALC increments it;
//   OUT is skipped (CALC->IDLE, no out_valid) while the count after increment < TAPS;
//   the TAPS-th and later samples emit outputs. flush clears counters.
//  Not defined: no counters; every accepted sample produces an output from the first one.
// TESTING
//  1 ch0 sends 4,4,4,4,4 (TAPS=4, out_ready=1) -> out_data 1,2,3,4,4, out_ch=0, each 2 cycles after accept.
//  2 after reset all four req_valid held high -> grant order 0,1,2,3,0,1; one req_ready bit per accept.
//  3 out_ready low 5 cycles in OUT -> out_valid/out_data/out_ch stable, req_ready all 0, busy=1.
//  4 ch1 single sample -3 (-> out -1, floor of -0.75); then ch1 sample 2047 (DW=12) -> out 511, no overflow.
//  5 flush pulsed while OUT holding ch2 result -> out_valid 0 next cycle; ch2 then sends 8 -> out 2.
//  6 THEE_LPF_WARMUP_EN: ch3 sends 4,8,12,16 -> no output for first three, then 10; rst_n low mid-CALC -> all outputs 0 at once.

Source files
------------

// File: rtl/thee_lpf_channel_sequencer.sv
// thee_lpf_channel_sequencer
//
// Shares one moving-average low-pass datapath among NCH sample channels.
// A round-robin arbiter picks one requesting channel while the sequencer is
// idle. The accepted sample then goes through three phases:
//   IDLE  grant and capture the sample,
//   CALC  update that channel's TAPS-deep history and running sum,
//   OUT   present the average until the consumer takes it.
// Each channel keeps its own history, running sum and write pointer. Only the
// channel being processed has its state changed.
//
// Optional build macro:
//   THEE_LPF_WARMUP_EN  Each channel gets a warm-up counter that saturates at
//                       TAPS. A channel emits no output until TAPS samples have
//                       filled its history.
//
// Ports
//   clk        single clock, rising edge
//   rst_n      asynchronous active-low reset
//   req_valid  [NCH]     per-channel sample valid
//   req_data   [NCH*DW]  per-channel signed sample; channel i at [i*DW +: DW]
//   req_ready  [NCH]     one-hot grant; combinational, asserted in IDLE only
//   out_valid            filtered result valid (registered)
//   out_ready            consumer ready
//   out_data   [DW]      signed filtered result, floor(sum / TAPS)
//   out_ch     [log2 NCH] channel index of out_data
//   flush                synchronous clear of all channel state, drops in-flight work
//   busy                 sequencer not in IDLE (registered)

module thee_lpf_channel_sequencer #(
  parameter int NCH  = 4,
  parameter int DW   = 12,
  parameter int TAPS = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NCH-1:0]              req_valid,
  input  logic [NCH*DW-1:0]           req_data,
  output logic [NCH-1:0]              req_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DW-1:0]        out_data,
  output logic [$clog2(NCH)-1:0]      out_ch,
  input  logic                        flush,
  output logic                        busy
);

  localparam int CW = $clog2(NCH);
  localparam int TL = $clog2(TAPS);
  localparam int SW = DW + TL;
`ifdef THEE_LPF_WARMUP_EN
  localparam int CNTW = $clog2(TAPS + 1);
`endif

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Sign-extends a sample to the running-sum width.
  function automatic logic signed [SW-1:0] sext(input logic signed [DW-1:0] x);
    return {{TL{x[DW-1]}}, x};
  endfunction

  // Divides the sum by TAPS with an arithmetic shift, which rounds toward -inf.
  // The quotient of a sum of TAPS DW-bit samples always fits in DW bits.
  function automatic logic signed [DW-1:0] avg_floor(input logic signed [SW-1:0] s);
    logic signed [SW-1:0] q;
    q = s >>> TL;
    return q[DW-1:0];
  endfunction

  state_t                  state;
  logic [CW-1:0]           rr_ptr;

  // Per-channel state, flattened into packed vectors:
  //   hist_q : channel c, tap t at [(c*TAPS + t)*DW +: DW]
  //   sum_q  : channel c at [c*SW +: SW]
  //   wp_q   : channel c at [c*TL +: TL]
  logic [NCH*TAPS*DW-1:0]  hist_q;
  logic [NCH*SW-1:0]       sum_q;
  logic [NCH*TL-1:0]       wp_q;
`ifdef THEE_LPF_WARMUP_EN
  logic [NCH*CNTW-1:0]     cnt_q;
  logic [CNTW-1:0]         cnt_cur_p1;
  logic [CNTW-1:0]         cnt_inc_p1;
`endif

  // Round-robin grant search. It starts at rr_ptr and wraps modulo NCH.
  logic                    gnt_any;
  logic [CW-1:0]           gnt_idx;
  logic [CW:0]             scan;
  logic signed [DW-1:0]    gnt_sample;

  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    scan    = '0;
    if (state == S_IDLE && !flush) begin
      for (int i = 0; i < NCH; i++) begin
        scan = {1'b0, rr_ptr} + (CW+1)'(i);
        if (scan >= (CW+1)'(NCH)) begin
          scan = scan - (CW+1)'(NCH);
        end
        if (!gnt_any && req_valid[scan[CW-1:0]]) begin
          gnt_any = 1'b1;
          gnt_idx = scan[CW-1:0];
        end
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  assign gnt_sample = req_data[gnt_idx*DW +: DW];

  // ---- p0: sample captured at grant ----
  logic signed [DW-1:0]    sample_p0;
  logic [CW-1:0]           ch_p0;

  // ---- p1: history / running-sum update for the captured channel ----
  logic [TL-1:0]           wp_cur_p1;
  logic signed [DW-1:0]    oldest_p1;
  logic signed [SW-1:0]    sum_cur_p1;
  logic signed [SW-1:0]    new_sum_p1;
  logic                    emit_p1;

  assign wp_cur_p1  = wp_q[ch_p0*TL +: TL];
  assign oldest_p1  = hist_q[(int'(ch_p0)*TAPS + int'(wp_cur_p1))*DW +: DW];
  assign sum_cur_p1 = sum_q[ch_p0*SW +: SW];
  assign new_sum_p1 = sum_cur_p1 + sext(sample_p0) - sext(oldest_p1);

`ifdef THEE_LPF_WARMUP_EN
  assign cnt_cur_p1 = cnt_q[ch_p0*CNTW +: CNTW];
  assign cnt_inc_p1 = (cnt_cur_p1 == CNTW'(TAPS)) ? cnt_cur_p1 : cnt_cur_p1 + 1'b1;
  // The output is held back until this sample completes the history.
  assign emit_p1    = (cnt_inc_p1 == CNTW'(TAPS));
`else
  assign emit_p1    = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      sample_p0 <= '0;
      ch_p0     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      busy      <= 1'b0;
      hist_q    <= '0;
      sum_q     <= '0;
      wp_q      <= '0;
`ifdef THEE_LPF_WARMUP_EN
      cnt_q     <= '0;
`endif
    end else if (flush) begin
      // Flush takes priority over every phase and drops any in-flight sample.
      // rr_ptr is kept so arbitration fairness survives the flush.
      // An OUT transfer in this same cycle has already completed at the port.
      state     <= S_IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      hist_q    <= '0;
      sum_q     <= '0;
      wp_q      <= '0;
`ifdef THEE_LPF_WARMUP_EN
      cnt_q     <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (gnt_any) begin
            sample_p0 <= gnt_sample;
            ch_p0     <= gnt_idx;
            rr_ptr    <= (gnt_idx == CW'(NCH-1)) ? '0 : gnt_idx + 1'b1;
            state     <= S_CALC;
            busy      <= 1'b1;
          end
        end

        S_CALC: begin
          hist_q[(int'(ch_p0)*TAPS + int'(wp_cur_p1))*DW +: DW] <= sample_p0;
          sum_q[ch_p0*SW +: SW] <= new_sum_p1;
          // TAPS is a power of two, so the pointer wraps naturally.
          wp_q[ch_p0*TL +: TL]  <= wp_cur_p1 + 1'b1;
`ifdef THEE_LPF_WARMUP_EN
          cnt_q[ch_p0*CNTW +: CNTW] <= cnt_inc_p1;
`endif
          if (emit_p1) begin
            out_data  <= avg_floor(new_sum_p1);
            out_ch    <= ch_p0;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end else begin
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end

        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
            busy      <= 1'b0;
          end
        end

        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_thee_lpf_channel_sequencer.sv
// Testbench for thee_lpf_channel_sequencer (NCH=4, DW=12, TAPS=4).
// Directed table vectors, hand-written corner sequences and randomized traffic.
// All of it is checked every cycle against a transaction-level reference model.

module tb_thee_lpf_channel_sequencer;

  localparam int NCH  = 4;
  localparam int DW   = 12;
  localparam int TAPS = 4;
`ifdef THEE_LPF_WARMUP_EN
  localparam bit WARM = 1'b1;
`else
  localparam bit WARM = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic [NCH-1:0]         req_valid;
  logic [NCH*DW-1:0]      req_data;
  logic [NCH-1:0]         req_ready;
  logic                   out_valid;
  logic                   out_ready;
  logic signed [DW-1:0]   out_data;
  logic [1:0]             out_ch;
  logic                   flush;
  logic                   busy;

  thee_lpf_channel_sequencer #(.NCH(NCH), .DW(DW), .TAPS(TAPS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .flush     (flush),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d required %0d", name, act, exp);
    end
  endtask

  // Reference model.
  // Each channel's history is a shift list, newest sample first.
  // The average is the exact integer mean, floored.
  // m_st is the protocol phase: 0 waiting, 1 computing, 2 presenting.
  int hist [NCH][TAPS];
  int nacc [NCH];
  int rr;
  int m_st;
  int e_data, e_ch;
  bit e_emit;
  int last_g;

  function automatic int fdiv(int s);
    if (s >= 0) return s / TAPS;
    return -((-s + TAPS - 1) / TAPS);
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      nacc[c] = 0;
      for (int t = 0; t < TAPS; t++) hist[c][t] = 0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    rr   = 0;
    m_st = 0;
  endtask

  task automatic model_accept(int g, int s);
    int sum;
    for (int t = TAPS - 1; t > 0; t--) hist[g][t] = hist[g][t-1];
    hist[g][0] = s;
    if (nacc[g] < TAPS) nacc[g]++;
    sum = 0;
    for (int t = 0; t < TAPS; t++) sum += hist[g][t];
    e_data = fdiv(sum);
    e_ch   = g;
    e_emit = !WARM || (nacc[g] >= TAPS);
    rr     = (g + 1) % NCH;
  endtask

  // Checks one clock cycle against the model, using the inputs already driven.
  // Then advances the model and returns at the next falling edge.
  task automatic cycle(output bit acc, output bit xfer);
    int g;
    logic [NCH-1:0] er;
    logic signed [DW-1:0] s;
    #1;
    g  = -1;
    er = '0;
    if (m_st == 0 && !flush) begin
      for (int i = 0; i < NCH; i++) begin
        int c;
        c = (rr + i) % NCH;
        if (g < 0 && req_valid[c]) g = c;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", int'(req_ready), int'(er));
    chk("req_ready_onehot", ($countones(req_ready) <= 1) ? 1 : 0, 1);
    chk("out_valid", int'(out_valid), (m_st == 2) ? 1 : 0);
    chk("busy", int'(busy), (m_st != 0) ? 1 : 0);
    if (m_st == 2) begin
      chk("out_data", int'(out_data), e_data);
      chk("out_ch", int'(out_ch), e_ch);
    end
    last_g = -1;
    for (int i = 0; i < NCH; i++) if (req_ready[i]) last_g = i;
    acc  = |(req_valid & req_ready);
    xfer = out_valid && out_ready;
    if (flush) begin
      model_clear();
      m_st = 0;
    end else if (m_st == 0) begin
      if (g >= 0) begin
        s = req_data[g*DW +: DW];
        model_accept(g, int'(s));
        m_st = 1;
      end
    end else if (m_st == 1) begin
      m_st = e_emit ? 2 : 0;
    end else if (out_ready) begin
      m_st = 0;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", int'(req_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    chk("rst_busy", int'(busy), 0);
    model_reset();
    rst_n = 1'b1;
  endtask

  // Presents one sample on channel ch and waits, bounded, for its grant.
  task automatic accept_one(int ch, int val);
    bit acc, x;
    int n;
    req_valid = '0;
    req_valid[ch] = 1'b1;
    req_data[ch*DW +: DW] = DW'(val);
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      cycle(acc, x);
      n++;
    end
    chk("accept_in_time", int'(acc), 1);
    req_valid = '0;
  endtask

  typedef struct {
    int ch;
    int val;
    bit emit;
    int exp;
  } vec_t;
  vec_t tbl [11];

  task automatic run_vec(int idx);
    bit acc, x, got;
    int d, c;
    out_ready = 1'b1;
    accept_one(tbl[idx].ch, tbl[idx].val);
    got = 1'b0;
    d = 0;
    c = 0;
    for (int k = 0; k < 3; k++) begin
      if (out_valid && !got) begin
        got = 1'b1;
        d = int'(out_data);
        c = int'(out_ch);
      end
      cycle(acc, x);
    end
    chk($sformatf("vec%0d_emit", idx), int'(got), int'(tbl[idx].emit));
    if (tbl[idx].emit) begin
      chk($sformatf("vec%0d_data", idx), d, tbl[idx].exp);
      chk($sformatf("vec%0d_ch", idx), c, tbl[idx].ch);
    end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, x;
    int k, n;
    int order [6];
    int fch, fexp;

    tbl[0]  = '{ch: 0, val: 4,    emit: !WARM, exp: 1};
    tbl[1]  = '{ch: 0, val: 4,    emit: !WARM, exp: 2};
    tbl[2]  = '{ch: 0, val: 4,    emit: !WARM, exp: 3};
    tbl[3]  = '{ch: 0, val: 4,    emit: 1'b1,  exp: 4};
    tbl[4]  = '{ch: 0, val: 4,    emit: 1'b1,  exp: 4};
    tbl[5]  = '{ch: 1, val: -3,   emit: !WARM, exp: -1};
    tbl[6]  = '{ch: 1, val: 2047, emit: !WARM, exp: 511};
    tbl[7]  = '{ch: 3, val: 4,    emit: !WARM, exp: 1};
    tbl[8]  = '{ch: 3, val: 8,    emit: !WARM, exp: 3};
    tbl[9]  = '{ch: 3, val: 12,   emit: !WARM, exp: 6};
    tbl[10] = '{ch: 2, val: 8,    emit: !WARM, exp: 2};

    req_data = '0;
    do_reset();

    for (int i = 0; i < 10; i++) run_vec(i);

    // Hold the result in OUT for five cycles while every channel requests.
    out_ready = 1'b0;
    accept_one(3, 16);
    k = 0;
    while (!out_valid && k < 5) begin
      cycle(acc, x);
      k++;
    end
    chk("hold_reached_out", int'(out_valid), 1);
    req_valid = '1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", int'(out_valid), 1);
      chk("hold_out_data", int'(out_data), 10);
      chk("hold_out_ch", int'(out_ch), 3);
      chk("hold_req_ready", int'(req_ready), 0);
      chk("hold_busy", int'(busy), 1);
      cycle(acc, x);
    end
    req_valid = '0;
    out_ready = 1'b1;
    cycle(acc, x);
    cycle(acc, x);

    // Flush while a result is held in OUT; the channel restarts from empty.
    fch  = WARM ? 3 : 2;
    fexp = WARM ? 34 : 25;
    out_ready = 1'b0;
    accept_one(fch, 100);
    k = 0;
    while (!out_valid && k < 5) begin
      cycle(acc, x);
      k++;
    end
    chk("flush_pre_valid", int'(out_valid), 1);
    chk("flush_pre_data", int'(out_data), fexp);
    cycle(acc, x);
    flush = 1'b1;
    cycle(acc, x);
    flush = 1'b0;
    chk("flush_out_valid", int'(out_valid), 0);
    chk("flush_busy", int'(busy), 0);
    run_vec(10);

    // Round-robin order after reset with all channels requesting.
    do_reset();
    req_data[0*DW +: DW] = DW'(40);
    req_data[1*DW +: DW] = DW'(-80);
    req_data[2*DW +: DW] = DW'(120);
    req_data[3*DW +: DW] = DW'(-7);
    req_valid = '1;
    out_ready = 1'b1;
    n = 0;
    k = 0;
    while (n < 6 && k < 60) begin
      cycle(acc, x);
      if (acc) begin
        order[n] = last_g;
        n++;
      end
      k++;
    end
    req_valid = '0;
    chk("grant_count", n, 6);
    for (int i = 0; i < 6; i++) chk($sformatf("grant_order%0d", i), order[i], i % NCH);
    for (int i = 0; i < 4; i++) cycle(acc, x);

    // Asynchronous reset while in CALC: outputs drop without waiting for a clock.
    accept_one(1, 500);
    chk("calc_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", int'(out_valid), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_req_ready", int'(req_ready), 0);
    chk("arst_out_data", int'(out_data), 0);
    chk("arst_out_ch", int'(out_ch), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized traffic with occasional flushes and consumer back-pressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      req_valid = NCH'($urandom);
      for (int c = 0; c < NCH; c++) req_data[c*DW +: DW] = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 49) == 0);
      cycle(acc, x);
    end
    flush = 1'b0;
    req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
